// File: rtl/fft_bin_streamer_pkg.sv
// Shared definitions for the FFT result streamer.
// Holds the default geometry (DATA_W, ROWS, COLS, NBINS, IDX_W), the bin and
// index types, the streamer state enum, and the index bit-reversal helper used
// when the streamer is built with BITREV_ORDER_EN defined.
package fft_bin_streamer_pkg;

   localparam int DATA_W = 16;
   localparam int ROWS   = 8;
   localparam int COLS   = 8;
   localparam int NBINS  = ROWS * COLS;
   localparam int IDX_W  = $clog2(NBINS);

   typedef logic [DATA_W-1:0] bin_t;
   typedef logic [IDX_W-1:0]  bin_idx_t;

   typedef enum logic {IDLE, STREAM} streamer_state_t;

   // Reverses the low w bits of v; bits above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

endpackage

// File: rtl/fft_bin_streamer_if.sv
// Valid/ready bin stream carrying one complex FFT bin per beat.
//   out_valid  master->slave  beat present
//   out_ready  slave->master  beat accepted
//   out_real   master->slave  real component
//   out_imag   master->slave  imag component
//   out_index  master->slave  bin index of the beat
//   out_last   master->slave  final beat of the frame
interface fft_bin_streamer_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 6
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_real;
   logic [DATA_W-1:0] out_imag;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;

   modport master (output out_valid, out_real, out_imag, out_index, out_last,
                   input  out_ready);
   modport slave  (input  out_valid, out_real, out_imag, out_index, out_last,
                   output out_ready);
endinterface

// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: snapshots the DFT engine's ROWSxCOLS real/imag result
// matrices on its one-cycle done pulse and drains the bins one per beat on a
// valid/ready stream, so the engine can begin its next frame immediately.
// Ports:
//   clk, areset_n      clock, asynchronous active-low reset
//   done               capture strobe from the DFT engine
//   realfft, imagfft   bin matrices, sampled in the done cycle
//   strm               bin stream (master side)
//   busy               a frame is held or draining
//   overrun            sticky: done arrived while a frame was still draining
//   clear_overrun      synchronous clear of overrun (a new overrun wins)
// Build option: define BITREV_ORDER_EN to emit bins in bit-reversed index
// order; handshake and timing are unchanged.
module fft_bin_streamer #(
   parameter int DATA_W = 16,
   parameter int ROWS   = 8,
   parameter int COLS   = 8
) (
   input  logic                                  clk,
   input  logic                                  areset_n,
   input  logic                                  done,
   input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] realfft,
   input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] imagfft,
   fft_bin_streamer_if.master                    strm,
   output logic                                  busy,
   output logic                                  overrun,
   input  logic                                  clear_overrun
);
   import fft_bin_streamer_pkg::*;

   localparam int NB = ROWS * COLS;
   localparam int IW = $clog2(NB);

   streamer_state_t            state_q, state_d;
   logic [IW-1:0]              pos_q;
   logic [IW-1:0]              idx;
   logic [NB-1:0][DATA_W-1:0]  buf_re, buf_im;
   logic                       hs, final_hs, capture, ovr_set;

   always_comb begin
      hs       = strm.out_valid & strm.out_ready;
      final_hs = hs && (pos_q == IW'(NB - 1));
      // A frame is accepted when idle, or when the last beat leaves this cycle.
      capture  = done && ((state_q == IDLE) || final_hs);
      ovr_set  = done && !capture;
      state_d  = state_q;
      case (state_q)
         IDLE:    if (done) state_d = STREAM;
         STREAM:  if (final_hs && !done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // The matrices flatten row-major, so buffer entry r*COLS+c is bin (r,c).
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         pos_q   <= '0;
         buf_re  <= '0;
         buf_im  <= '0;
         overrun <= 1'b0;
      end else begin
         if (capture) begin
            pos_q  <= '0;
            buf_re <= realfft;
            buf_im <= imagfft;
         end else if (hs) begin
            pos_q  <= pos_q + 1'b1;
         end
         if (ovr_set)            overrun <= 1'b1;
         else if (clear_overrun) overrun <= 1'b0;
      end
   end

`ifdef BITREV_ORDER_EN
   always_comb idx = IW'(bitrev(32'(pos_q), IW));
`else
   always_comb idx = pos_q;
`endif

   // Outputs come straight off the held buffer and counter, so they stay
   // stable for as long as a beat is stalled.
   assign strm.out_valid = (state_q == STREAM);
   assign strm.out_real  = buf_re[idx];
   assign strm.out_imag  = buf_im[idx];
   assign strm.out_index = idx;
   assign strm.out_last  = (pos_q == IW'(NB - 1));
   assign busy           = (state_q == STREAM);

endmodule

// File: tb/tb_fft_bin_streamer.sv
module tb_fft_bin_streamer;

   typedef struct packed {
      logic [5:0]  idx;
      logic [15:0] re;
      logic [15:0] im;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic areset_n = 1'b0;
   logic done = 1'b0;
   logic clear_overrun = 1'b0;
   logic rdy = 1'b0;
   logic [7:0][7:0][15:0] re_v = '0;
   logic [7:0][7:0][15:0] im_v = '0;
   logic busy, overrun;

   fft_bin_streamer_if #(.DATA_W(16), .IDX_W(6)) sif ();
   assign sif.out_ready = rdy;

   fft_bin_streamer #(.DATA_W(16), .ROWS(8), .COLS(8)) dut (
      .clk           (clk),
      .areset_n      (areset_n),
      .done          (done),
      .realfft       (re_v),
      .imagfft       (im_v),
      .strm          (sif),
      .busy          (busy),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clk = ~clk;

   beat_t q[$];
   logic  exp_ovr = 1'b0;
   int    nchk = 0;
   int    nerr = 0;

   // Emitted bin index for sequence position k.
   function automatic int exp_idx(input int k);
`ifdef BITREV_ORDER_EN
      int r;
      r = 0;
      for (int b = 0; b < 6; b++) if (((k >> b) & 1) != 0) r = r + (1 << (5 - b));
      return r;
`else
      return k;
`endif
   endfunction

   // Reference model: the queue holds the beats still owed downstream.
   always @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         q.delete();
         exp_ovr <= 1'b0;
      end else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (clear_overrun) exp_ovr <= 1'b0;
         if (done) begin
            if (q.size() == 0) begin
               for (int k = 0; k < 64; k++) begin
                  beat_t b;
                  int    ix;
                  ix     = exp_idx(k);
                  b.idx  = 6'(ix);
                  b.re   = re_v[ix / 8][ix % 8];
                  b.im   = im_v[ix / 8][ix % 8];
                  b.last = (k == 63);
                  q.push_back(b);
               end
            end else begin
               exp_ovr <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   logic  stall = 1'b0;
   beat_t held;

   always @(negedge clk) begin
      if (!areset_n) begin
         chk("rst_valid", 32'(sif.out_valid), 32'd0);
         chk("rst_busy",  32'(busy),          32'd0);
         chk("rst_ovr",   32'(overrun),       32'd0);
         chk("rst_last",  32'(sif.out_last),  32'd0);
         chk("rst_index", 32'(sif.out_index), 32'd0);
         chk("rst_real",  32'(sif.out_real),  32'd0);
         chk("rst_imag",  32'(sif.out_imag),  32'd0);
         stall <= 1'b0;
      end else begin
         chk("valid",   32'(sif.out_valid), 32'(q.size() > 0));
         chk("busy",    32'(busy),          32'(q.size() > 0));
         chk("overrun", 32'(overrun),       32'(exp_ovr));
         if (stall && sif.out_valid) begin
            chk("hold_index", 32'(sif.out_index), 32'(held.idx));
            chk("hold_real",  32'(sif.out_real),  32'(held.re));
            chk("hold_imag",  32'(sif.out_imag),  32'(held.im));
            chk("hold_last",  32'(sif.out_last),  32'(held.last));
         end
         if (sif.out_valid && q.size() > 0) begin
            if (rdy) begin
               chk("beat_index", 32'(sif.out_index), 32'(q[0].idx));
               chk("beat_real",  32'(sif.out_real),  32'(q[0].re));
               chk("beat_imag",  32'(sif.out_imag),  32'(q[0].im));
               chk("beat_last",  32'(sif.out_last),  32'(q[0].last));
            end
            stall     <= !rdy;
            held.idx  <= sif.out_index;
            held.re   <= sif.out_real;
            held.im   <= sif.out_imag;
            held.last <= sif.out_last;
         end else begin
            stall <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: real=r*8+c, imag=~real; mode 1: real=0x1000+p; mode 2: random
   task automatic load_frame(input int mode);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            case (mode)
               0: begin re_v[r][c] = 16'(r * 8 + c);          im_v[r][c] = ~re_v[r][c]; end
               1: begin re_v[r][c] = 16'(32'h1000 + r * 8 + c); im_v[r][c] = ~re_v[r][c]; end
               default: begin re_v[r][c] = 16'($urandom); im_v[r][c] = 16'($urandom); end
            endcase
         end
   endtask

   task automatic pulse_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   // Runs until at most n beats remain owed; random ready when rnd is set.
   task automatic wait_left(input int n, input bit rnd, input int budget);
      int cyc;
      cyc = 0;
      while (q.size() > n) begin
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         cyc++;
         if (cyc > budget) begin
            $display("FAIL timeout: %0d beats left, required %0d", q.size(), n);
            $fatal(1, "stream timeout");
         end
      end
   endtask

   initial begin
      repeat (3) tick();
      areset_n = 1'b1;
      tick();

      // Ordered frame at full rate.
      rdy = 1'b1;
      load_frame(0);
      pulse_done();
      wait_left(0, 1'b0, 200);
      repeat (3) tick();

      // Random backpressure.
      load_frame(2);
      pulse_done();
      wait_left(0, 1'b1, 1000);
      rdy = 1'b1;
      repeat (2) tick();

      // New frame on the final handshake, full rate then with backpressure.
      load_frame(0);
      pulse_done();
      wait_left(1, 1'b0, 200);
      load_frame(1);
      pulse_done();
      wait_left(1, 1'b1, 1000);
      while (!rdy) begin rdy = 1'($urandom_range(0, 1)); if (!rdy) tick(); end
      load_frame(2);
      pulse_done();
      wait_left(0, 1'b1, 1000);
      rdy = 1'b1;
      repeat (2) tick();

      // Overrun at position 10, then clear; then clear against a new overrun.
      load_frame(0);
      pulse_done();
      wait_left(54, 1'b0, 100);
      load_frame(2);
      pulse_done();
      repeat (5) tick();
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      repeat (3) tick();
      load_frame(2);
      done = 1'b1;
      clear_overrun = 1'b1;
      tick();
      done = 1'b0;
      clear_overrun = 1'b0;
      wait_left(0, 1'b1, 1000);
      rdy = 1'b1;
      tick();

      // Reset in the middle of a frame with overrun set.
      load_frame(2);
      pulse_done();
      wait_left(40, 1'b0, 100);
      pulse_done();
      repeat (3) tick();
      areset_n = 1'b0;
      repeat (2) tick();
      areset_n = 1'b1;
      repeat (2) tick();

      // Random soak: backpressure, stray done pulses, stray clears.
      for (int i = 0; i < 3000; i++) begin
         rdy           = 1'($urandom_range(0, 1));
         done          = ($urandom_range(0, 39) == 0);
         clear_overrun = ($urandom_range(0, 49) == 0);
         if (done) load_frame(2);
         tick();
      end
      done = 1'b0;
      clear_overrun = 1'b0;
      wait_left(0, 1'b0, 200);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
